// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic skew feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FEED,
    DRAIN
  } state_e;

  // Step counter must reach 2*n-1 so it never wraps within a tile.
  function automatic int unsigned step_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  function automatic int unsigned drain_cycles(input int unsigned n);
    return n;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane_mux.sv
// One skewed lane: picks element (t - lane) of a buffered row/column, or 0 outside the tile.
module skew_lane_mux #(
  parameter int unsigned data_size = 8,
  parameter int unsigned n_dim     = 4,
  parameter int unsigned lane      = 0,
  parameter int unsigned t_width   = 3
) (
  input  logic [t_width-1:0]         t,
  input  logic [n_dim*data_size-1:0] elems,
  output logic [data_size-1:0]       value
);

  always_comb begin
    value = '0;
    for (int unsigned k = 0; k < n_dim; k++) begin
      if (32'(t) == k + lane) value = elems[k*data_size +: data_size];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one A/B tile and drives diagonally skewed operands into the PE mesh edges.
// Build option FEEDER_BACK2BACK_EN: two banks, next tile loads into the shadow bank during FEED/DRAIN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned data_size = 8,
  parameter int unsigned n_dim     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [n_dim*data_size-1:0] ld_a_row,
  input  logic [n_dim*data_size-1:0] ld_b_row,
  output logic [n_dim*data_size-1:0] a_out,
  output logic [n_dim*data_size-1:0] b_out,
  output logic                       acc_clear,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned TW           = step_width(n_dim);
  localparam int unsigned CW           = $clog2(n_dim + 1);
  localparam int unsigned RW           = $clog2(n_dim);
  localparam int unsigned DRAIN_CYCLES = drain_cycles(n_dim);
`ifdef FEEDER_BACK2BACK_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam logic [TW-1:0] T_LAST = TW'(2 * n_dim - 1);
  localparam logic [TW-1:0] D_LAST = TW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] FULL   = CW'(n_dim);

  typedef logic [n_dim*data_size-1:0] row_t;

  row_t a_buf [NB][n_dim];
  row_t b_buf [NB][n_dim];
  row_t b_col [n_dim];
  row_t a_skew, b_skew;

  state_e        state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          act, act_nxt, ld_bank, accept;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    cnt_nxt   = cnt;
    act_nxt   = act;
    ld_ready  = 1'b0;
    acc_clear = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    ld_bank   = act;
    unique case (state)
      IDLE, LOAD: ld_ready = 1'b1;
      CLEAR:      acc_clear = 1'b1;
      FEED, DRAIN: begin
`ifdef FEEDER_BACK2BACK_EN
        ld_ready = (cnt != FULL);
        ld_bank  = ~act;
`endif
      end
      default: ;
    endcase
    accept = ld_valid && ld_ready;
    if (accept) cnt_nxt = cnt + CW'(1);

    // t is the step loaded into a_out/b_out at the next edge, so it runs one ahead of the visible step.
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        if (cnt_nxt == FULL) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          t_nxt     = '0;
        end
      end
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = t + TW'(1);
      end
      FEED: begin
        if (t == T_LAST) begin
          state_nxt = DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      DRAIN: begin
        if (t == D_LAST) begin
          done  = 1'b1;
          t_nxt = '0;
`ifdef FEEDER_BACK2BACK_EN
          if (cnt_nxt == FULL) begin
            state_nxt = CLEAR;
            act_nxt   = ~act;
            cnt_nxt   = '0;
          end else if (cnt_nxt != '0) begin
            state_nxt = LOAD;
            act_nxt   = ~act;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
      cnt   <= '0;
      act   <= 1'b0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      cnt   <= cnt_nxt;
      act   <= act_nxt;
      if (state == CLEAR || state == FEED) begin
        a_out <= a_skew;
        b_out <= b_skew;
      end else begin
        a_out <= '0;
        b_out <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_buf[ld_bank][cnt[RW-1:0]] <= ld_a_row;
      b_buf[ld_bank][cnt[RW-1:0]] <= ld_b_row;
    end
  end

  // B is loaded by rows but each north lane streams a column.
  always_comb begin
    b_col = '{default: '0};
    for (int unsigned j = 0; j < n_dim; j++) begin
      for (int unsigned k = 0; k < n_dim; k++) begin
        b_col[j][k*data_size +: data_size] = b_buf[act][k][j*data_size +: data_size];
      end
    end
  end

  for (genvar i = 0; i < n_dim; i++) begin : g_lane
    skew_lane_mux #(
      .data_size(data_size),
      .n_dim    (n_dim),
      .lane     (i),
      .t_width  (TW)
    ) u_a_mux (
      .t    (t),
      .elems(a_buf[act][i]),
      .value(a_skew[i*data_size +: data_size])
    );
    skew_lane_mux #(
      .data_size(data_size),
      .n_dim    (n_dim),
      .lane     (i),
      .t_width  (TW)
    ) u_b_mux (
      .t    (t),
      .elems(b_col[i]),
      .value(b_skew[i*data_size +: data_size])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: random tiles and handshakes vs. a tile-level skew model.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DS = 8;
  localparam int W  = N * DS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ld_valid = 1'b0;
  logic [W-1:0] ld_a_row = '0;
  logic [W-1:0] ld_b_row = '0;
  logic         ld_ready, acc_clear, busy, done;
  logic [W-1:0] a_out, b_out;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [DS-1:0] ma [N][N];
  logic [DS-1:0] mb [N][N];
  logic [DS-1:0] ya [N][N];
  logic [DS-1:0] yb [N][N];

  systolic_skew_feeder #(.data_size(DS), .n_dim(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_a_row (ld_a_row),
    .ld_b_row (ld_b_row),
    .a_out    (a_out),
    .b_out    (b_out),
    .acc_clear(acc_clear),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // West lane i carries A[i][s-i]; north lane j carries B[s-j][j].
  function automatic logic [W-1:0] exp_a(input int s);
    logic [W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (s - i >= 0 && s - i < N) v[i*DS +: DS] = ma[i][s-i];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_b(input int s);
    logic [W-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (s - j >= 0 && s - j < N) v[j*DS +: DS] = mb[s-j][j];
    return v;
  endfunction

  task automatic rand_tile();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DS'($urandom);
        mb[i][k] = DS'($urandom);
      end
  endtask

  // Entered and left 1 time unit after a rising edge; returns right after beat N is accepted.
  task automatic load_tile(input bit alt);
    int r = 0;
    int guard = 0;
    bit v;
    while (r < N && guard < 200) begin
      v = alt ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
      ld_valid = v;
      for (int k = 0; k < N; k++) begin
        ld_a_row[k*DS +: DS] = v ? ma[r][k] : DS'($urandom);
        ld_b_row[k*DS +: DS] = v ? mb[r][k] : DS'($urandom);
      end
      @(negedge clk);
      check($sformatf("load r=%0d ld_ready", r), ld_ready, 1);
      check($sformatf("load r=%0d busy", r), busy, r > 0);
      @(posedge clk); #1;
      if (v) r++;
      guard++;
    end
    ld_valid = 1'b0;
    if (r < N) check("load beat budget", r, N);
  endtask

  // k counts cycles after the edge that accepted beat N.
  task automatic run_phase(input string nm, input bit spec_vec);
    for (int k = 1; k <= 3 * N; k++) begin
      @(negedge clk);
`ifdef FEEDER_BACK2BACK_EN
      check($sformatf("%s k=%0d ld_ready", nm, k), ld_ready, k != 1);
`else
      check($sformatf("%s k=%0d ld_ready", nm, k), ld_ready, 0);
      ld_valid = (k < 3 * N);
      ld_a_row = W'($urandom);
      ld_b_row = W'($urandom);
`endif
      check($sformatf("%s k=%0d acc_clear", nm, k), acc_clear, k == 1);
      check($sformatf("%s k=%0d busy", nm, k), busy, 1);
      check($sformatf("%s k=%0d done", nm, k), done, k == 3 * N);
      check($sformatf("%s k=%0d a_out", nm, k), a_out, (k >= 2 && k <= 2 * N) ? exp_a(k - 2) : '0);
      check($sformatf("%s k=%0d b_out", nm, k), b_out, (k >= 2 && k <= 2 * N) ? exp_b(k - 2) : '0);
      if (spec_vec && k == 2) begin
        check("tile1 t=0 a_out", a_out, 32'h0000_0001);
        check("tile1 t=0 b_out", b_out, 32'h0000_0001);
      end
      if (spec_vec && k == 5) begin
        check("tile1 t=3 a_out", a_out, 32'h0D0A_0704);
        check("tile1 t=3 b_out", b_out, 32'h0000_0000);
      end
      if (spec_vec && k == 8) check("tile1 t=6 b_out", b_out, 32'h0100_0000);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check({nm, " idle busy"}, busy, 0);
    check({nm, " idle ld_ready"}, ld_ready, 1);
    check({nm, " idle a_out"}, a_out, '0);
    @(posedge clk); #1;
  endtask

`ifdef FEEDER_BACK2BACK_EN
  task automatic b2b_test();
    int r = 0;
    rand_tile();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ya[i][k] = DS'($urandom);
        yb[i][k] = DS'($urandom);
      end
    load_tile(0);
    for (int k = 1; k <= 3 * N; k++) begin
      @(negedge clk);
      check($sformatf("b2b k=%0d ld_ready", k), ld_ready, (k != 1) && (r < N));
      check($sformatf("b2b k=%0d busy", k), busy, 1);
      check($sformatf("b2b k=%0d acc_clear", k), acc_clear, k == 1);
      check($sformatf("b2b k=%0d done", k), done, k == 3 * N);
      check($sformatf("b2b k=%0d a_out", k), a_out, (k >= 2 && k <= 2 * N) ? exp_a(k - 2) : '0);
      check($sformatf("b2b k=%0d b_out", k), b_out, (k >= 2 && k <= 2 * N) ? exp_b(k - 2) : '0);
      ld_valid = (k >= 2 && r < N);
      if (ld_valid) begin
        for (int c = 0; c < N; c++) begin
          ld_a_row[c*DS +: DS] = ya[r][c];
          ld_b_row[c*DS +: DS] = yb[r][c];
        end
        r++;
      end
    end
    ld_valid = 1'b0;
    ma = ya;
    mb = yb;
    run_phase("b2b tile2", 0);
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset a_out", a_out, '0);
    check("reset b_out", b_out, '0);
    check("reset acc_clear", acc_clear, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ld_ready", ld_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = DS'(i * N + k + 1);
        mb[i][k] = DS'(i == k);
      end
    load_tile(0);
    run_phase("tile1", 1);

    rand_tile();
    load_tile(1);
    run_phase("tile2", 0);

    rand_tile();
    load_tile(0);
    repeat (4) @(negedge clk);
    check("pre-reset a_out t=2", a_out, exp_a(2));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid reset a_out", a_out, '0);
    check("mid reset b_out", b_out, '0);
    check("mid reset busy", busy, 0);
    check("mid reset ld_ready", ld_ready, 1);
    for (int k = 0; k < 3 * N; k++) begin
      check($sformatf("post reset quiet %0d", k), {acc_clear, done, busy}, 3'b000);
      @(negedge clk);
    end
    @(posedge clk); #1;

    rand_tile();
    load_tile(0);
    run_phase("tile3", 0);

`ifdef FEEDER_BACK2BACK_EN
    b2b_test();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
